// File: rtl/instruction_fetch_stage.sv
// Fetch stage with IF/ID register: issues word fetches over a req/ready handshake,
// absorbs wait states, downstream stalls and branch redirects, and feeds decode.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [5:0]  if_id_op,
  output logic [31:0] if_id_pc_plus4
);

  typedef enum logic [1:0] {IDLE, FETCH, KILL, BUFFER} stateT;

  function automatic logic [31:0] pcPlus4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  function automatic logic [31:0] alignAddr(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  stateT       state, stateNext;
  logic [31:0] pc, pcNext;
  logic [31:0] redirectPc, redirectNext;
  logic [31:0] bufWord, bufNext;
  logic        idLoad, idBubble;
  logic [31:0] idInstrNext, idPc4Next;
  logic [31:0] targetAligned;

  assign targetAligned = alignAddr(branch_target);
  assign imem_req      = (state == FETCH) || (state == KILL);
  assign imem_addr     = pc;
  assign if_id_op      = if_id_instr[31:26];

  always_comb begin
    stateNext    = state;
    pcNext       = pc;
    redirectNext = redirectPc;
    bufNext      = bufWord;
    idLoad       = 1'b0;
    // Flush beats stall; otherwise any unstalled cycle without a load is a bubble.
    idBubble     = branch_taken || !stall;
    idInstrNext  = imem_rdata;
    idPc4Next    = pcPlus4(pc);
    case (state)
      IDLE: begin
        stateNext = FETCH;
        if (branch_taken) pcNext = targetAligned;
      end
      FETCH: begin
        if (branch_taken) begin
          if (imem_ready) begin
            pcNext = targetAligned;
          end else begin
            redirectNext = targetAligned;
            stateNext    = KILL;
          end
        end else if (imem_ready) begin
          pcNext = pcPlus4(pc);
          if (!stall) begin
            idLoad = 1'b1;
          end else begin
            bufNext   = imem_rdata;
            stateNext = BUFFER;
          end
        end
      end
      KILL: begin
        // The in-flight word is thrown away; a newer branch replaces the pending target.
        if (branch_taken) redirectNext = targetAligned;
        if (imem_ready) begin
          pcNext    = branch_taken ? targetAligned : redirectPc;
          stateNext = FETCH;
        end
      end
      BUFFER: begin
        if (branch_taken) begin
          pcNext    = targetAligned;
          bufNext   = 32'h0;
          stateNext = FETCH;
        end else if (!stall) begin
          idLoad      = 1'b1;
          idInstrNext = bufWord;
          idPc4Next   = pc;
          stateNext   = FETCH;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pc             <= alignAddr(RESET_PC);
      redirectPc     <= 32'h0;
      bufWord        <= 32'h0;
      if_id_valid    <= 1'b0;
      if_id_instr    <= 32'h0;
      if_id_pc_plus4 <= 32'h0;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      redirectPc <= redirectNext;
      bufWord    <= bufNext;
      if (idLoad) begin
        if_id_valid    <= 1'b1;
        if_id_instr    <= idInstrNext;
        if_id_pc_plus4 <= idPc4Next;
      end else if (idBubble) begin
        if_id_valid <= 1'b0;
        if_id_instr <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: variable-latency memory model, fetch-order
// scoreboard and next-address model, plus directed reset/stall/branch/wrap checks.
module tb_instruction_fetch_stage;

  localparam logic [31:0] PC_A = 32'h00400000;
  localparam logic [31:0] PC_W = 32'hFFFFFFFC;

  logic        clk;
  logic        rst, imem_req, imem_ready, stall, branch_taken, if_id_valid;
  logic [31:0] imem_addr, imem_rdata, branch_target, if_id_instr, if_id_pc_plus4;
  logic [5:0]  if_id_op;

  logic        rstW, imem_reqW, imem_readyW, stallW, branchW, if_id_validW;
  logic [31:0] imem_addrW, imem_rdataW, targetW, if_id_instrW, if_id_pc_plus4W;
  logic [5:0]  if_id_opW;

  int vectors = 0;
  int miscompares = 0;
  int latency;
  int waitCnt;
  logic monOn;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } sbEntryT;
  sbEntryT sbQ[$];
  sbEntryT e;

  logic        pReq, pRdy, pStall, pBr, prevValid, killFlag;
  logic [31:0] pAddr, pTgt, prevInstr, prevPc4, expAddr, pendTgt;
  logic [31:0] savedAddr, tmp;

  instruction_fetch_stage #(.RESET_PC(PC_A)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_op(if_id_op),
    .if_id_pc_plus4(if_id_pc_plus4)
  );

  instruction_fetch_stage #(.RESET_PC(PC_W)) dutWrap (
    .clk(clk), .rst(rstW), .imem_req(imem_reqW), .imem_addr(imem_addrW),
    .imem_ready(imem_readyW), .imem_rdata(imem_rdataW), .stall(stallW),
    .branch_taken(branchW), .branch_target(targetW),
    .if_id_valid(if_id_validW), .if_id_instr(if_id_instrW), .if_id_op(if_id_opW),
    .if_id_pc_plus4(if_id_pc_plus4W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[7:2], a[27:2] ^ 26'h2A5A5A5};
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory: ready rises once a request has waited `latency` cycles.
  initial begin
    imem_ready = 1'b0; imem_rdata = 32'h0; waitCnt = 0;
    imem_readyW = 1'b1; imem_rdataW = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) imem_ready = 1'b0;
      else imem_ready = imem_req && (waitCnt >= latency);
      imem_rdata  = memWord(imem_addr);
      imem_rdataW = memWord(imem_addrW);
      @(posedge clk);
      if (rst) waitCnt = 0;
      else if (imem_req && imem_ready) waitCnt = 0;
      else if (imem_req) waitCnt++;
    end
  end

  // Scoreboard and next-address model, updated from pre-edge values.
  always @(posedge clk) begin
    if (!monOn) begin
      sbQ.delete();
      expAddr  = PC_A;
      killFlag = 1'b0;
      pendTgt  = 32'h0;
    end else begin
      pReq = imem_req; pRdy = imem_ready; pAddr = imem_addr;
      pStall = stall; pBr = branch_taken; pTgt = branch_target & 32'hFFFF_FFFC;
      prevValid = if_id_valid; prevInstr = if_id_instr; prevPc4 = if_id_pc_plus4;
      if (pReq && pRdy) begin
        if (killFlag) begin
          expAddr  = pBr ? pTgt : pendTgt;
          killFlag = 1'b0;
        end else if (pBr) begin
          expAddr = pTgt;
        end else begin
          sbQ.push_back({memWord(pAddr), pAddr + 32'd4});
          expAddr = pAddr + 32'd4;
        end
      end else if (pBr) begin
        if (pReq) begin
          killFlag = 1'b1;
          pendTgt  = pTgt;
        end else begin
          sbQ.delete();
          expAddr = pTgt;
        end
      end
      #1;
      if (pBr) begin
        checkVal("flushValid", 32'(if_id_valid), 32'd0);
        checkVal("flushInstr", if_id_instr, 32'd0);
        checkVal("flushPc4", if_id_pc_plus4, prevPc4);
      end else if (pStall) begin
        checkVal("holdValid", 32'(if_id_valid), 32'(prevValid));
        checkVal("holdInstr", if_id_instr, prevInstr);
        checkVal("holdPc4", if_id_pc_plus4, prevPc4);
      end else if (if_id_valid) begin
        checkVal("sbDepth", 32'(sbQ.size()), 32'd1);
        if (sbQ.size() > 0) begin
          e = sbQ.pop_front();
          checkVal("sbInstr", if_id_instr, e.instr);
          checkVal("sbPc4", if_id_pc_plus4, e.pc4);
          checkVal("sbOp", 32'(if_id_op), 32'(e.instr[31:26]));
        end
      end
      checkVal("nextAddr", imem_addr, expAddr);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rstW = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    latency = 0; monOn = 1'b0; stallW = 1'b0; branchW = 1'b0; targetW = 32'h0;
    #2;
    checkVal("rstReq", 32'(imem_req), 32'd0);
    checkVal("rstAddr", imem_addr, PC_A);
    checkVal("rstValid", 32'(if_id_valid), 32'd0);
    checkVal("rstInstr", if_id_instr, 32'd0);
    checkVal("rstOp", 32'(if_id_op), 32'd0);
    checkVal("rstPc4", if_id_pc_plus4, 32'd0);
    checkVal("rstAddrW", imem_addrW, PC_W);

    // Reset and run with ready tied high
    @(negedge clk); rst = 1'b0; monOn = 1'b1;
    @(negedge clk);
    checkVal("runReq", 32'(imem_req), 32'd1);
    checkVal("runAddr0", imem_addr, 32'h00400000);
    @(negedge clk);
    checkVal("runValid", 32'(if_id_valid), 32'd1);
    checkVal("runPc4", if_id_pc_plus4, 32'h00400004);
    checkVal("runAddr1", imem_addr, 32'h00400004);
    tmp = memWord(32'h00400000);
    checkVal("runOp", 32'(if_id_op), 32'(tmp[31:26]));
    @(negedge clk);
    checkVal("runAddr2", imem_addr, 32'h00400008);
    repeat (3) @(negedge clk);

    // Three wait states
    @(posedge clk); #2 latency = 3;
    @(negedge clk);
    savedAddr = imem_addr;
    checkVal("waitReq0", 32'(imem_req), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkVal("waitReq", 32'(imem_req), 32'd1);
      checkVal("waitAddr", imem_addr, savedAddr);
      checkVal("waitValid", 32'(if_id_valid), 32'd0);
    end
    @(negedge clk);
    checkVal("waitDone", 32'(if_id_valid), 32'd1);
    checkVal("waitPc4", if_id_pc_plus4, savedAddr + 32'd4);
    @(posedge clk); #2 latency = 0;
    repeat (2) @(negedge clk);

    // Stall with data in flight
    @(negedge clk); stall = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkVal("bufReq", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    @(negedge clk);
    checkVal("relValid", 32'(if_id_valid), 32'd1);
    checkVal("relPc4", if_id_pc_plus4, imem_addr);
    repeat (2) @(negedge clk);

    // Branch while a word sits in the skid buffer (unaligned target)
    @(negedge clk); stall = 1'b1;
    @(negedge clk); branch_taken = 1'b1; branch_target = 32'h00400302;
    @(negedge clk); branch_taken = 1'b0; stall = 1'b0;
    checkVal("bbValid", 32'(if_id_valid), 32'd0);
    checkVal("bbAddr", imem_addr, 32'h00400300);
    checkVal("bbReq", 32'(imem_req), 32'd1);
    repeat (3) @(negedge clk);

    // Branch during a two-cycle wait
    @(posedge clk); #2 latency = 2;
    @(negedge clk);
    savedAddr = imem_addr; branch_taken = 1'b1; branch_target = 32'h00400100;
    @(negedge clk); branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkVal("killReq", 32'(imem_req), 32'd1);
      checkVal("killAddr", imem_addr, savedAddr);
      checkVal("killValid", 32'(if_id_valid), 32'd0);
      @(negedge clk);
    end
    checkVal("tgtAddr", imem_addr, 32'h00400100);
    checkVal("tgtReq", 32'(imem_req), 32'd1);
    checkVal("tgtValid", 32'(if_id_valid), 32'd0);
    @(posedge clk); #2 latency = 0;
    repeat (3) @(negedge clk);

    // Branch and stall in the same cycle
    @(negedge clk); stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h00400200;
    @(negedge clk); stall = 1'b0; branch_taken = 1'b0;
    checkVal("bsValid", 32'(if_id_valid), 32'd0);
    checkVal("bsAddr", imem_addr, 32'h00400200);
    checkVal("bsReq", 32'(imem_req), 32'd1);
    @(negedge clk);
    checkVal("bsTgtValid", 32'(if_id_valid), 32'd1);
    checkVal("bsTgtPc4", if_id_pc_plus4, 32'h00400204);
    repeat (2) @(negedge clk);
    checkVal("sbDrain", 32'(sbQ.size()), 32'd0);

    // Address wrap
    rstW = 1'b0;
    @(negedge clk);
    checkVal("wrapReq", 32'(imem_reqW), 32'd1);
    checkVal("wrapAddr0", imem_addrW, 32'hFFFFFFFC);
    @(negedge clk);
    checkVal("wrapAddr1", imem_addrW, 32'h00000000);
    checkVal("wrapPc4", if_id_pc_plus4W, 32'h00000000);
    checkVal("wrapValid", 32'(if_id_validW), 32'd1);
    checkVal("wrapInstr", if_id_instrW, memWord(32'hFFFFFFFC));

    // Asynchronous reset in the middle of a wait
    @(posedge clk); #2 latency = 3;
    @(negedge clk);
    @(posedge clk); #3;
    monOn = 1'b0; rst = 1'b1;
    #1;
    checkVal("arstReq", 32'(imem_req), 32'd0);
    checkVal("arstAddr", imem_addr, PC_A);
    checkVal("arstValid", 32'(if_id_valid), 32'd0);
    checkVal("arstInstr", if_id_instr, 32'd0);
    checkVal("arstOp", 32'(if_id_op), 32'd0);
    checkVal("arstPc4", if_id_pc_plus4, 32'd0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0; latency = 0; monOn = 1'b1;
    @(negedge clk);
    checkVal("rerunReq", 32'(imem_req), 32'd1);
    checkVal("rerunAddr", imem_addr, PC_A);
    @(negedge clk);
    checkVal("rerunValid", 32'(if_id_valid), 32'd1);
    checkVal("rerunPc4", if_id_pc_plus4, 32'h00400004);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

- Fetch stage and IF/ID pipeline register that sit directly upstream of the opcode-decoding control unit.
- Holds the PC and issues word fetches to instruction memory over a variable-latency req/ready handshake.
- Absorbs memory wait states, downstream stalls and branch redirects.
- Presents a registered instruction, its `op` field and PC+4 to the decode stage.

## Interface
Parameters:
- `RESET_PC`, default 32'h00000000: address of the first fetch after reset.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; bits [1:0] always 0.
- `imem_ready`  in  1  memory returns data this cycle; sampled only while `imem_req`=1.
- `imem_rdata`  in  32  instruction word; valid when `imem_req`&`imem_ready`.
- `stall`  in  1  hazard hold: IF/ID must keep its contents.
- `branch_taken`  in  1  redirect request, single-cycle pulse.
- `branch_target`  in  32  redirect address; bits [1:0] ignored and forced to 0.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_instr`  out  32  registered instruction word; 32'h00000000 when invalid.
- `if_id_op`  out  6  `if_id_instr[31:26]`, drives the control unit `op` input.
- `if_id_pc_plus4`  out  32  address of the instruction plus 4.

## Operation
- Registers:
  - `pc`: address of the current or next request.
  - `redirect`: pending branch target.
  - `buf`: skid buffer holding one word.
  - The IF/ID registers.
  - FSM state.
- FSM states: IDLE, FETCH, KILL, BUFFER. Reset state is IDLE; IDLE moves to FETCH unconditionally on the next edge.
- `imem_req`=1 only in FETCH or KILL, and `imem_addr`=`pc` in every state. While a request is outstanding, addr and req stay stable until `imem_ready`.
- FETCH, with `branch_taken` taking priority:
  - `branch_taken` & `imem_ready`: discard `imem_rdata`; `pc`<=target; stay in FETCH.
  - `branch_taken` & !`imem_ready`: `redirect`<=target; go to KILL.
  - `imem_ready` & !`stall`: IF/ID<={rdata, pc+4, valid=1}; `pc`<=pc+4.
  - `imem_ready` & `stall`: `buf`<=rdata; `pc`<=pc+4; go to BUFFER.
  - !`imem_ready` & !`stall`: load a bubble into IF/ID.
- KILL:
  - The outstanding request completes and its data is discarded.
  - On `imem_ready`: `pc`<=`redirect`; go to FETCH.
  - A new `branch_taken` in KILL overwrites `redirect`.
  - Nothing from KILL ever reaches IF/ID.
- BUFFER:
  - No request is issued.
  - !`stall`: IF/ID<={buf, pc, valid=1}. `pc` already equals buffered address + 4. Go to FETCH.
  - `branch_taken`: drop `buf`; `pc`<=target; go to FETCH.
- IF/ID update rules:
  - `branch_taken` forces a bubble on the next edge regardless of `stall`; flush beats stall.
  - Otherwise `stall`=1 holds all IF/ID registers unchanged.
  - A bubble is `valid`=0, `instr`=0, `pc_plus4` unchanged.
- Arithmetic: `pc`+4 is 32-bit modulo; 32'hFFFFFFFC wraps to 32'h00000000.
- Ordering: instructions enter IF/ID strictly in fetch order, with none lost or duplicated across stalls.

## Timing
- Reset values, applied asynchronously on `rst`=1:
  - `pc`=`RESET_PC`, state IDLE, `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `if_id_valid`=0, `if_id_instr`=0, `if_id_op`=0, `if_id_pc_plus4`=0.
  - `buf`=0, `redirect`=0.
- First edge after `rst` deasserts: state goes IDLE to FETCH, and `imem_req` rises.
- Latency: with `imem_ready` high in the request cycle, the instruction is in IF/ID after 1 edge.
- Throughput: with ready held at 1 and no stall, one instruction per cycle.
- Each wait-state cycle inserts one bubble, unless `stall` holds IF/ID.
- Redirect penalty with `imem_ready` tied to 1: the target is requested in the cycle after `branch_taken`.
- Redirect from KILL: the target request follows the edge on which the killed request completes.
- Reset mid-transaction: `rst` abandons any outstanding request immediately. `imem_req` drops asynchronously, and memory must tolerate the abandoned request.

## Test plan
- Reset and run:
  - Stimulus: `RESET_PC`=32'h00400000, ready tied 1, no stall.
  - Required: `imem_addr` sequence 00400000, 00400004, 00400008.
  - Required: one cycle after the first request, `if_id_valid`=1 and `if_id_pc_plus4`=32'h00400004.
  - Required: `if_id_op`=instr[31:26].
- Wait states:
  - Stimulus: `imem_ready` asserted 3 cycles after the request.
  - Required: `imem_req`/`imem_addr` stable for all 3 cycles.
  - Required: `if_id_valid`=0 during the wait and 1 after the ready edge.
- Stall with data:
  - Stimulus: `stall`=1 for 4 cycles while ready=1.
  - Required: one word is buffered and `imem_req`=0 in BUFFER.
  - Required: IF/ID is frozen during the stall, the buffered word appears after release, and the stream has no gaps or duplicates.
- Branch in flight:
  - Stimulus: `branch_taken` with target 32'h00400100 during a 2-cycle wait.
  - Required: the old request completes with the same addr, and its data is never valid in IF/ID.
  - Required: the next request is to 00400100.
- Branch + stall same cycle:
  - Required: `if_id_valid`=0 on the next edge, and a fetch of the target follows.
- Wrap and async reset:
  - Stimulus: `RESET_PC`=32'hFFFFFFFC.
  - Required: the next addr is 00000000 and `if_id_pc_plus4`=0.
  - Stimulus: assert `rst` mid-wait.
  - Required: all outputs return to their reset values without waiting for a `clk` edge.
